mult32x32_fsm: RTL and testbench

MULT32X32_FSM -- requirements
Module: mult32x32_fsm

---
 rtl/mult32x32_fsm.sv | 138 +++++++++++++
 tb/tb_mult32x32_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mult32x32_fsm.sv
// Sequencer for a 32x32 multiply built from eight 8x16 partial products.
// Latency: clear on the start edge, eight accumulate cycles, product final after the 8th.
// Backpressure: none; start is ignored while busy (no queuing, no restart).
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous active-high reset, forces IDLE
//   start      request a new multiply, honoured only in IDLE
//   busy       high in every non-IDLE state
//   a_sel      byte of operand A presented to the arithmetic unit
//   b_sel      16-bit half of operand B presented to the arithmetic unit
//   shift_sel  partial-product shift in bytes (0..5)
//   upd_prod   accumulate the shifted partial product this cycle
//   clr_prod   clear the product register on the coming edge
module mult32x32_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic [1:0] a_sel,
    output logic       b_sel,
    output logic [2:0] shift_sel,
    output logic       upd_prod,
    output logic       clr_prod
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        A0B0 = 4'd1,
        A1B0 = 4'd2,
        A2B0 = 4'd3,
        A3B0 = 4'd4,
        A0B1 = 4'd5,
        A1B1 = 4'd6,
        A2B1 = 4'd7,
        A3B1 = 4'd8
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus Moore outputs decoded from the state register.
    // clr_prod is the only Mealy output: it fires in IDLE with start so the
    // clearing edge is the same edge that enters A0B0. It is gated by reset
    // because a held start must not clear the product while reset holds IDLE.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        a_sel     = 2'd0;
        b_sel     = 1'b0;
        shift_sel = 3'd0;
        upd_prod  = 1'b1;
        clr_prod  = 1'b0;

        case (state)
            IDLE: begin
                busy     = 1'b0;
                upd_prod = 1'b0;
                clr_prod = start & ~reset;
                if (start) begin
                    state_nxt = A0B0;
                end
            end
            A0B0: begin
                a_sel     = 2'd0;
                b_sel     = 1'b0;
                shift_sel = 3'd0;
                state_nxt = A1B0;
            end
            A1B0: begin
                a_sel     = 2'd1;
                b_sel     = 1'b0;
                shift_sel = 3'd1;
                state_nxt = A2B0;
            end
            A2B0: begin
                a_sel     = 2'd2;
                b_sel     = 1'b0;
                shift_sel = 3'd2;
                state_nxt = A3B0;
            end
            A3B0: begin
                a_sel     = 2'd3;
                b_sel     = 1'b0;
                shift_sel = 3'd3;
                state_nxt = A0B1;
            end
            // Upper half of B carries an extra 16-bit weight: shift = i + 2.
            A0B1: begin
                a_sel     = 2'd0;
                b_sel     = 1'b1;
                shift_sel = 3'd2;
                state_nxt = A1B1;
            end
            A1B1: begin
                a_sel     = 2'd1;
                b_sel     = 1'b1;
                shift_sel = 3'd3;
                state_nxt = A2B1;
            end
            A2B1: begin
                a_sel     = 2'd2;
                b_sel     = 1'b1;
                shift_sel = 3'd4;
                state_nxt = A3B1;
            end
            A3B1: begin
                a_sel     = 2'd3;
                b_sel     = 1'b1;
                shift_sel = 3'd5;
                state_nxt = IDLE;
            end
            default: begin
                // Unused encodings fall back to IDLE with idle outputs.
                busy      = 1'b0;
                upd_prod  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Structural invariants of the schedule.
    a_no_overlap: assert property (@(posedge clk) disable iff (reset)
        !(upd_prod && clr_prod));
    a_shift_range: assert property (@(posedge clk) disable iff (reset)
        shift_sel <= 3'd5);
    a_busy_state: assert property (@(posedge clk) disable iff (reset)
        busy == (state != IDLE));

endmodule

// File: tb/tb_mult32x32_fsm.sv
module tb_mult32x32_fsm;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy;
    logic [1:0] a_sel;
    logic       b_sel;
    logic [2:0] shift_sel;
    logic       upd_prod;
    logic       clr_prod;

    logic [31:0] a_op;
    logic [31:0] b_op;
    logic [63:0] product;

    int tests_run;
    int tests_failed;

    // Hand-derived per-step selects for A0B0..A3B1.
    logic [1:0] exp_a  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic       exp_b  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0] exp_sh [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4, 3'd5};

    mult32x32_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .shift_sel (shift_sel),
        .upd_prod  (upd_prod),
        .clr_prod  (clr_prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8x16 arithmetic unit and product register.
    always @(posedge clk) begin
        logic [7:0]  a_byte;
        logic [15:0] b_half;
        logic [63:0] pp;
        a_byte = a_op[8*a_sel +: 8];
        b_half = b_op[16*b_sel +: 16];
        pp     = 64'(a_byte) * 64'(b_half);
        if (clr_prod)
            product <= 64'd0;
        else if (upd_prod)
            product <= product + (pp << (8 * shift_sel));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to the next falling edge and check the per-cycle invariants.
    task automatic tick();
        @(negedge clk);
        #1;
        check("no_upd_and_clr", 64'(upd_prod & clr_prod), 64'd0);
        check("shift_le_5", 64'(shift_sel > 3'd5), 64'd0);
    endtask

    task automatic check_step(input string tag, input int s);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_upd"}, 64'(upd_prod), 64'd1);
        check({tag, "_clr"}, 64'(clr_prod), 64'd0);
        check({tag, "_a_sel"}, 64'(a_sel), 64'(exp_a[s]));
        check({tag, "_b_sel"}, 64'(b_sel), 64'(exp_b[s]));
        check({tag, "_shift"}, 64'(shift_sel), 64'(exp_sh[s]));
    endtask

    // One complete multiply; poke_step >= 0 raises start during that step.
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp_prod, input int poke_step);
        tick();
        a_op  = a;
        b_op  = b;
        start = 1'b1;
        #1;
        check({tag, "_clr_on_start"}, 64'(clr_prod), 64'd1);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        for (int s = 0; s < 8; s++) begin
            tick();
            start = (s == poke_step);
            #1;
            check_step(tag, s);
        end
        tick();
        start = 1'b0;
        #1;
        check({tag, "_done_busy"}, 64'(busy), 64'd0);
        check({tag, "_done_upd"}, 64'(upd_prod), 64'd0);
        check({tag, "_product"}, product, exp_prod);
        tick();
        check({tag, "_stays_idle"}, 64'(busy), 64'd0);
        check({tag, "_product_stable"}, product, exp_prod);
    endtask

    initial begin
        int waited;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        start        = 1'b0;
        a_op         = 32'd0;
        b_op         = 32'd0;

        // Reset state, including a start that must not clear under reset.
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_upd", 64'(upd_prod), 64'd0);
        check("rst_a_sel", 64'(a_sel), 64'd0);
        check("rst_b_sel", 64'(b_sel), 64'd0);
        check("rst_shift", 64'(shift_sel), 64'd0);
        start = 1'b1;
        #1;
        check("rst_clr_with_start", 64'(clr_prod), 64'd0);
        tick();
        check("rst_hold_busy", 64'(busy), 64'd0);
        start = 1'b0;
        reset = 1'b0;

        // First start after release is honoured on the first edge.
        run_mult("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
        run_mult("mixed", 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, -1);
        run_mult("start_busy", 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 3);

        // start held high: a new run begins every 9 cycles with one idle clear.
        tick();
        a_op  = 32'd3;
        b_op  = 32'd5;
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) tick();
            #1;
            if ((c % 9) == 0) begin
                check("held_idle_clr", 64'(clr_prod), 64'd1);
                check("held_idle_busy", 64'(busy), 64'd0);
                if (c > 0) check("held_product", product, 64'd15);
            end else begin
                check_step("held", (c % 9) - 1);
            end
        end
        tick();
        start  = 1'b0;
        waited = 0;
        while (busy && waited < 12) begin
            tick();
            waited++;
        end
        check("held_drain_timeout", 64'(busy), 64'd0);
        check("held_last_product", product, 64'd15);

        // Reset in A2B1 aborts asynchronously.
        tick();
        a_op  = 32'h0F0F_0F0F;
        b_op  = 32'h1111_1111;
        start = 1'b1;
        for (int s = 0; s < 7; s++) begin
            tick();
            start = 1'b0;
            #1;
            check_step("pre_abort", s);
        end
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_upd", 64'(upd_prod), 64'd0);
        check("abort_clr", 64'(clr_prod), 64'd0);
        check("abort_a_sel", 64'(a_sel), 64'd0);
        check("abort_b_sel", 64'(b_sel), 64'd0);
        check("abort_shift", 64'(shift_sel), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_abort_idle", 64'(busy), 64'd0);
            check("post_abort_upd", 64'(upd_prod), 64'd0);
        end
        run_mult("after_abort", 32'd7, 32'd6, 64'd42, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
